// File: rtl/counter_pkg.sv
// Shared types and defaults for the modulo-N counter family.
// Direction encoding matches the raw dir port value so it can be used directly.
package counter_pkg;

  typedef enum logic {
    CNT_DIR_UP   = 1'b0,
    CNT_DIR_DOWN = 1'b1
  } cnt_dir_t;

  localparam int CNT_MOD_DEFAULT = 12;

endpackage

// File: rtl/counter_mod_n.sv
// Modulo-N up/down counter (down mode only with COUNTER_MODN_DIR_EN); out and load_err registered, 1-cycle latency.
// No backpressure: priority is clr > load > valid_count > hold; tc is combinational for same-edge cascading.
module counter_mod_n
  import counter_pkg::*;
#(
  parameter int MOD   = CNT_MOD_DEFAULT,
  parameter int WIDTH = $clog2(MOD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_count,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             load_err
);

  if (MOD < 2) begin : g_bad_mod
    $error("counter_mod_n: MOD must be at least 2");
  end
  if (((MOD - 1) >> WIDTH) != 0) begin : g_bad_width
    $error("counter_mod_n: WIDTH too small to hold MOD-1");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  cnt_dir_t         dir_s;
  logic             load_oor;
  logic             at_term;

`ifdef COUNTER_MODN_DIR_EN
  assign dir_s = dir ? CNT_DIR_DOWN : CNT_DIR_UP;
`else
  logic unused_dir;
  assign unused_dir = dir;
  assign dir_s      = CNT_DIR_UP;
`endif

  assign load_oor = 32'(load_val) >= MOD;
  assign at_term  = (dir_s == CNT_DIR_DOWN) ? (cnt_q == '0) : (cnt_q == MAX_VAL);

  // Suppressed under clr/load so a downstream stage never steps on a cycle this one is overridden.
  assign tc = valid_count && !clr && !load && at_term;

  always_comb begin
    cnt_d = cnt_q;
    err_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if (load_oor) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        cnt_d = load_val;
      end
    end else if (valid_count) begin
      if (dir_s == CNT_DIR_DOWN) begin
        cnt_d = (cnt_q == '0) ? MAX_VAL : cnt_q - WIDTH'(1);
      end else begin
        cnt_d = (cnt_q == MAX_VAL) ? '0 : cnt_q + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign out      = cnt_q;
  assign load_err = err_q;

endmodule

// File: tb/tb_counter_mod_n.sv
// Bench for counter_mod_n: three moduli (12, 16, 5) driven in parallel against an arithmetic model.
// Down-mode expectations follow COUNTER_MODN_DIR_EN when it is defined for the build.
module tb_counter_mod_n;

`ifdef COUNTER_MODN_DIR_EN
  localparam bit DIR_EN = 1'b1;
`else
  localparam bit DIR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_count = 1'b0;
  logic       clr = 1'b0;
  logic       load = 1'b0;
  logic       dir = 1'b0;
  logic [3:0] lv = 4'd0;
  logic [2:0] lv5;
  logic [3:0] o12, o16;
  logic [2:0] o5;
  logic       tc12, tc16, tc5, e12, e16, e5;

  int mods[3] = '{12, 16, 5};
  int m_out[3];
  bit m_err[3];
  int n_checks = 0;
  int n_errors = 0;

  assign lv5 = lv[2:0];

  always #5 clk = ~clk;

  counter_mod_n #(.MOD(12)) u12 (
    .clk(clk), .rst_n(rst_n), .valid_count(valid_count), .clr(clr), .load(load),
    .load_val(lv), .dir(dir), .out(o12), .tc(tc12), .load_err(e12));
  counter_mod_n #(.MOD(16), .WIDTH(4)) u16 (
    .clk(clk), .rst_n(rst_n), .valid_count(valid_count), .clr(clr), .load(load),
    .load_val(lv), .dir(dir), .out(o16), .tc(tc16), .load_err(e16));
  counter_mod_n #(.MOD(5)) u5 (
    .clk(clk), .rst_n(rst_n), .valid_count(valid_count), .clr(clr), .load(load),
    .load_val(lv5), .dir(dir), .out(o5), .tc(tc5), .load_err(e5));

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int load_of(int i);
    return (i == 2) ? int'(lv5) : int'(lv);
  endfunction

  function automatic bit model_tc(int i);
    bit down;
    down = DIR_EN && dir;
    if (!valid_count || clr || load) return 1'b0;
    return down ? (m_out[i] == 0) : (m_out[i] == mods[i] - 1);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_out[i] = 0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      m_err[i] = 1'b0;
      if (clr) begin
        m_out[i] = 0;
      end else if (load) begin
        if (load_of(i) >= mods[i]) begin
          m_out[i] = 0;
          m_err[i] = 1'b1;
        end else begin
          m_out[i] = load_of(i);
        end
      end else if (valid_count) begin
        if (DIR_EN && dir) m_out[i] = (m_out[i] + mods[i] - 1) % mods[i];
        else               m_out[i] = (m_out[i] + 1) % mods[i];
      end
    end
  endtask

  task automatic check_all();
    check_eq("out12", int'(o12), m_out[0]);
    check_eq("out16", int'(o16), m_out[1]);
    check_eq("out5",  int'(o5),  m_out[2]);
    check_eq("err12", int'(e12), int'(m_err[0]));
    check_eq("err16", int'(e16), int'(m_err[1]));
    check_eq("err5",  int'(e5),  int'(m_err[2]));
    check_eq("tc12",  int'(tc12), int'(model_tc(0)));
    check_eq("tc16",  int'(tc16), int'(model_tc(1)));
    check_eq("tc5",   int'(tc5),  int'(model_tc(2)));
  endtask

  // Apply inputs, check mid-cycle, advance the model on the rising edge.
  task automatic drive_cycle(input bit vc, input bit c, input bit l, input logic [3:0] v, input bit d);
    valid_count = vc;
    clr = c;
    load = l;
    lv = v;
    dir = d;
    @(negedge clk);
    check_all();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    #12;
    check_all();
    check_eq("rst_out12", int'(o12), 0);
    #8 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 15; k++) drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("idle_out12", int'(o12), 0);

    for (int k = 0; k < 12; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("wrap12", int'(o12), 0);

    for (int k = 0; k < 7; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    for (int k = 0; k < 5; k++) drive_cycle(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("hold7", int'(o12), 7);
    for (int k = 0; k < 5; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("resume_wrap", int'(o12), 0);

    drive_cycle(1'b1, 1'b0, 1'b1, 4'd5, 1'b0);
    check_eq("load5", int'(o12), 5);
    drive_cycle(1'b0, 1'b0, 1'b1, 4'd13, 1'b0);
    check_eq("load13_out", int'(o12), 0);
    check_eq("load13_err", int'(e12), 1);
    drive_cycle(1'b0, 1'b1, 1'b1, 4'd13, 1'b0);
    check_eq("clr_load_err", int'(e12), 0);

    drive_cycle(1'b0, 1'b0, 1'b1, 4'd2, 1'b0);
    for (int k = 0; k < 4; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b1);
    check_eq("dir_end", int'(o12), DIR_EN ? 10 : 6);
    drive_cycle(1'b0, 1'b1, 1'b0, 4'd0, 1'b0);

    for (int k = 0; k < 9; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("pre_rst9", int'(o12), 9);
    valid_count = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("async_rst", int'(o12), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("post_rst", int'(o12), 3);

    drive_cycle(1'b0, 1'b0, 1'b1, 4'd15, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("wrap16", int'(o16), 0);
    drive_cycle(1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
    drive_cycle(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
    check_eq("wrap5", int'(o5), 0);

    for (int k = 0; k < 400; k++) begin
      drive_cycle($urandom_range(0, 9) < 7,
                  $urandom_range(0, 19) == 0,
                  $urandom_range(0, 9) == 0,
                  4'($urandom_range(0, 15)),
                  $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
